// File: rtl/seg_serial_driver.sv
// rtl/seg_serial_driver.sv - serial seven-segment chain driver with one-deep update queue
// Optional SEG_BCD_EN adds binary-to-decimal conversion (CONV state) selected by dec_mode.
module seg_serial_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  dec_mode,
  input  logic                  update,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_dt,
  output logic                  seg_en,
  output logic                  seg_clr
);

  localparam int NBITS = 8 * DIGITS;
  localparam int VW    = 4 * DIGITS;
  localparam int BW    = $clog2(NBITS);
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
`ifdef SEG_BCD_EN
  localparam logic [BW-1:0] CONV_LAST = BW'(VW - 1);
`endif

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
`ifdef SEG_BCD_EN
    S_CONV,
`endif
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]     div_cnt;
  logic              phase;
  logic [BW-1:0]     bit_cnt;
  logic              div_tick;

  logic [VW-1:0]     frame_val;
  logic [DIGITS-1:0] frame_dp;
  logic [DIGITS-1:0] frame_blank;

  logic              pending;
  logic [VW-1:0]     pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic [DIGITS-1:0] pend_blank;

  logic              start_new;
  logic              start_pend;
  logic              conv_active;
  logic [VW-1:0]     src_val;
  logic [DIGITS-1:0] src_dp;
  logic [DIGITS-1:0] src_blank;

  logic [7:0]        enc;
  logic [2:0]        bit_sel;

`ifdef SEG_BCD_EN
  logic              frame_dec;
  logic              frame_ovf;
  logic              pend_dec;
  logic              src_dec;
  logic [VW-1:0]     conv_bin;
  logic [VW-1:0]     bcd_adj;
  logic [DIGITS-1:0] lz_blank;
`else
  logic              unused_dec;
  assign unused_dec = dec_mode;
`endif

  function automatic logic [7:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  assign div_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_new   = 1'b0;
    start_pend  = 1'b0;
    conv_active = 1'b0;
    case (state)
      S_CLR:   if (div_tick && phase) state_nxt = S_IDLE;
      S_IDLE:  if (update) begin
                 start_new = 1'b1;
                 state_nxt = S_SHIFT;
               end
`ifdef SEG_BCD_EN
      S_CONV:  begin
                 conv_active = 1'b1;
                 if (bit_cnt == CONV_LAST) state_nxt = S_SHIFT;
               end
`endif
      S_SHIFT: if (div_tick && phase && bit_cnt == LAST_BIT) state_nxt = S_DONE;
      S_DONE:  begin
                 // A request in the DONE cycle is the newest one, so it beats the queued copy
                 state_nxt = S_IDLE;
                 if (update) begin
                   start_new = 1'b1;
                   state_nxt = S_SHIFT;
                 end else if (pending) begin
                   start_pend = 1'b1;
                   state_nxt  = S_SHIFT;
                 end
               end
      default: state_nxt = S_CLR;
    endcase
`ifdef SEG_BCD_EN
    if ((start_new && dec_mode) || (start_pend && pend_dec)) state_nxt = S_CONV;
`endif
    busy    = (state == S_SHIFT) || conv_active;
    done    = (state == S_DONE);
    seg_clr = (state != S_CLR);
    seg_clk = (state == S_SHIFT) && phase;
    seg_dt  = (state == S_SHIFT) && enc[bit_sel];
  end

  always_comb begin
    src_val   = start_new ? value      : pend_val;
    src_dp    = start_new ? dp_mask    : pend_dp;
    src_blank = start_new ? blank_mask : pend_blank;
`ifdef SEG_BCD_EN
    src_dec   = start_new ? dec_mode   : pend_dec;
`endif
  end

`ifdef SEG_BCD_EN
  // Double-dabble adjust, and leading-zero map taken from the converted digits
  always_comb begin
    logic seen;
    bcd_adj  = '0;
    lz_blank = '0;
    seen     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[i*4 +: 4] = (frame_val[i*4 +: 4] >= 4'd5) ? frame_val[i*4 +: 4] + 4'd3
                                                       : frame_val[i*4 +: 4];
    end
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (frame_val[i*4 +: 4] != 4'd0) seen = 1'b1;
      lz_blank[i] = ~seen;
    end
  end
`endif

  always_comb begin
    logic [3:0] nib;
    logic       dp_bit;
    logic       bl_bit;
    logic       lz_bit;
    int         cur;
    nib     = '0;
    dp_bit  = 1'b0;
    bl_bit  = 1'b0;
    lz_bit  = 1'b0;
    cur     = DIGITS - 1 - (int'(bit_cnt) >> 3);
    bit_sel = 3'd7 - bit_cnt[2:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (i == cur) begin
        nib    = frame_val[i*4 +: 4];
        dp_bit = frame_dp[i];
        bl_bit = frame_blank[i];
`ifdef SEG_BCD_EN
        lz_bit = lz_blank[i];
`endif
      end
    end
    enc = hex_seg(nib);
`ifdef SEG_BCD_EN
    if (frame_dec && frame_ovf) enc = 8'hBF;
`endif
    if (dp_bit) enc[7] = 1'b0;
`ifdef SEG_BCD_EN
    if (frame_dec && !frame_ovf && lz_bit) enc = 8'hFF;
`else
    if (lz_bit) enc = 8'hFF;
`endif
    if (bl_bit) enc = 8'hFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      frame_val   <= '0;
      frame_dp    <= '0;
      frame_blank <= '0;
      pending     <= 1'b0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      seg_en      <= 1'b0;
`ifdef SEG_BCD_EN
      frame_dec   <= 1'b0;
      frame_ovf   <= 1'b0;
      pend_dec    <= 1'b0;
      conv_bin    <= '0;
`endif
    end else begin
      // The CLR hold reuses the bit-period divider: one full bit period of clear
      if (state == S_CLR || state == S_SHIFT) begin
        if (div_tick) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end else begin
        div_cnt <= '0;
        phase   <= 1'b0;
      end

      if (state_nxt != state)
        bit_cnt <= '0;
      else if ((state == S_SHIFT && div_tick && phase) || conv_active)
        bit_cnt <= bit_cnt + BW'(1);

      if (start_new || start_pend) begin
        frame_val   <= src_val;
        frame_dp    <= src_dp;
        frame_blank <= src_blank;
`ifdef SEG_BCD_EN
        frame_dec   <= src_dec;
        frame_ovf   <= 1'b0;
        conv_bin    <= src_val;
        if (src_dec) frame_val <= '0;
`endif
      end
`ifdef SEG_BCD_EN
      else if (conv_active) begin
        // A carry out of the top digit means the value needs more digits than the chain has
        frame_val <= {bcd_adj[VW-2:0], conv_bin[VW-1]};
        frame_ovf <= frame_ovf | bcd_adj[VW-1];
        conv_bin  <= conv_bin << 1;
      end
`endif

      if (state == S_DONE) begin
        pending <= 1'b0;
      end else if (update && busy) begin
        pending    <= 1'b1;
        pend_val   <= value;
        pend_dp    <= dp_mask;
        pend_blank <= blank_mask;
`ifdef SEG_BCD_EN
        pend_dec   <= dec_mode;
`endif
      end

      if (state == S_SHIFT && state_nxt == S_DONE) seg_en <= 1'b1;
      else if (start_new || start_pend)            seg_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// tb/tb_seg_serial_driver.sv - directed self-checking bench for seg_serial_driver
// Decimal-mode cases run only when SEG_BCD_EN is defined.
module tb_seg_serial_driver;

  localparam int DIGITS  = 8;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  blank_mask = '0;
  logic        dec_mode = 1'b0;
  logic        update = 1'b0;
  logic        busy, done, seg_clk, seg_dt, seg_en, seg_clr;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] cap = '0;
  int          cap_n = 0;

  seg_serial_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .dec_mode(dec_mode), .update(update),
    .busy(busy), .done(done), .seg_clk(seg_clk), .seg_dt(seg_dt),
    .seg_en(seg_en), .seg_clr(seg_clr)
  );

  always #5 clk = ~clk;

  always @(posedge seg_clk) begin
    cap   = {cap[62:0], seg_dt};
    cap_n = cap_n + 1;
  end

  task automatic send_update(input logic [31:0] v, input logic [7:0] dp,
                             input logic [7:0] bl, input logic dec);
    @(negedge clk);
    value = v; dp_mask = dp; blank_mask = bl; dec_mode = dec;
    update = 1'b1;
    cap_n  = 0;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  task automatic wait_bits(input int target);
    int k;
    k = 0;
    while (cap_n < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({seg_clk, seg_dt, seg_en, seg_clr, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=000000", {seg_clk, seg_dt, seg_en, seg_clr, busy, done});
    end
    cap_n = 0;
    rst_n = 1'b1;
    n = 0;
    while (!seg_clr && n < 50) begin
      @(posedge clk);
      n++;
      #1;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL clr_hold got=%0d want=8", n);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({cap_n != 0, busy, seg_en, done} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_clr got edges=%0d busy=%b en=%b done=%b want 0", cap_n, busy, seg_en, done);
    end
  endtask

  task automatic test_hex_basic;
    int n;
    send_update(32'h0000_0001, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({busy, seg_en} !== 2'b10) begin
      errors++;
      $display("FAIL start_flags got busy=%b en=%b want busy=1 en=0", busy, seg_en);
    end
    wait_done(n);
    checks++;
    if (n !== 512) begin
      errors++;
      $display("FAIL done_latency got=%0d want=512", n);
    end
    checks++;
    if (cap_n !== 64 || cap !== 64'hC0C0C0C0C0C0C0F9) begin
      errors++;
      $display("FAIL frame_one got=%h bits=%0d want=c0c0c0c0c0c0c0f9 bits=64", cap, cap_n);
    end
    checks++;
    if ({seg_en, busy, seg_clk, seg_dt} !== 4'b1000) begin
      errors++;
      $display("FAIL done_cycle got en=%b busy=%b clk=%b dt=%b want 1000", seg_en, busy, seg_clk, seg_dt);
    end
    @(negedge clk);
    checks++;
    if ({done, seg_en, busy} !== 3'b010) begin
      errors++;
      $display("FAIL after_done got done=%b en=%b busy=%b want 010", done, seg_en, busy);
    end
  endtask

  task automatic test_hex_masks;
    int n;
    send_update(32'h1234_5678, 8'h01, 8'h80, 1'b0);
    wait_done(n);
    checks++;
    if (cap !== 64'hFFA4B0999282F800) begin
      errors++;
      $display("FAIL frame_masks got=%h want=ffa4b0999282f800", cap);
    end
    send_update(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0);
    wait_done(n);
    checks++;
    if (cap !== 64'h80908883C6A1868E) begin
      errors++;
      $display("FAIL frame_hex_hi got=%h want=80908883c6a1868e", cap);
    end
    send_update(32'h0000_0000, 8'hFF, 8'h0F, 1'b0);
    wait_done(n);
    checks++;
    if (cap !== 64'h40404040FFFFFFFF) begin
      errors++;
      $display("FAIL frame_dp_blank got=%h want=40404040ffffffff", cap);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    send_update(32'h0000_0001, 8'h00, 8'h00, 1'b0);
    wait_bits(10);
    value = 32'h2222_2222; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_bits(20);
    value = 32'hFFFF_FFFF; update = 1'b1;
    @(negedge clk);
    update = 1'b0; value = 32'h0;
    wait_done(n);
    checks++;
    if (cap !== 64'hC0C0C0C0C0C0C0F9) begin
      errors++;
      $display("FAIL b2b_first got=%h want=c0c0c0c0c0c0c0f9", cap);
    end
    cap_n = 0;
    @(negedge clk);
    checks++;
    if ({busy, done, seg_en} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_restart got busy=%b done=%b en=%b want 100", busy, done, seg_en);
    end
    wait_done(n);
    checks++;
    if (n !== 512 || cap_n !== 64 || cap !== 64'h8E8E8E8E8E8E8E8E) begin
      errors++;
      $display("FAIL b2b_second got=%h bits=%0d lat=%0d want=8e8e8e8e8e8e8e8e bits=64 lat=512", cap, cap_n, n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    send_update(32'hA5A5_A5A5, 8'h00, 8'h00, 1'b0);
    wait_bits(30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({seg_clk, seg_dt, seg_en, seg_clr, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b want=000000", {seg_clk, seg_dt, seg_en, seg_clr, busy, done});
    end
    repeat (2) @(negedge clk);
    cap_n = 0;
    rst_n = 1'b1;
    n = 0;
    while (!seg_clr && n < 50) begin
      @(posedge clk);
      n++;
      #1;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL mid_clr_hold got=%0d want=8", n);
    end
    repeat (80) @(negedge clk);
    checks++;
    if ({cap_n != 0, busy, seg_en} !== 3'b0) begin
      errors++;
      $display("FAIL mid_residual got edges=%0d busy=%b en=%b want 0", cap_n, busy, seg_en);
    end
    send_update(32'h0000_0010, 8'h00, 8'h00, 1'b0);
    wait_done(n);
    checks++;
    if (cap !== 64'hC0C0C0C0C0C0F9C0) begin
      errors++;
      $display("FAIL post_reset_frame got=%h want=c0c0c0c0c0c0f9c0", cap);
    end
  endtask

  task automatic test_dec;
    int n;
`ifdef SEG_BCD_EN
    send_update(32'd1234, 8'h00, 8'h00, 1'b1);
    wait_done(n);
    checks++;
    if (n !== 544 || cap !== 64'hFFFFFFFFF9A4B099) begin
      errors++;
      $display("FAIL bcd_1234 got=%h lat=%0d want=fffffffff9a4b099 lat=544", cap, n);
    end
    send_update(32'd100000000, 8'h01, 8'h00, 1'b1);
    wait_done(n);
    checks++;
    if (cap !== 64'hBFBFBFBFBFBFBF3F) begin
      errors++;
      $display("FAIL bcd_overflow got=%h want=bfbfbfbfbfbfbf3f", cap);
    end
    send_update(32'd99999999, 8'h00, 8'h00, 1'b1);
    wait_done(n);
    checks++;
    if (cap !== 64'h9090909090909090) begin
      errors++;
      $display("FAIL bcd_max got=%h want=9090909090909090", cap);
    end
    send_update(32'd0, 8'h00, 8'h00, 1'b1);
    wait_done(n);
    checks++;
    if (cap !== 64'hFFFFFFFFFFFFFFC0) begin
      errors++;
      $display("FAIL bcd_zero got=%h want=ffffffffffffffc0", cap);
    end
`else
    send_update(32'h0000_1234, 8'h00, 8'h00, 1'b1);
    wait_done(n);
    checks++;
    if (n !== 512 || cap !== 64'hC0C0C0C0F9A4B099) begin
      errors++;
      $display("FAIL dec_ignored got=%h lat=%0d want=c0c0c0c0f9a4b099 lat=512", cap, n);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_hex_basic;
    test_hex_masks;
    test_back_to_back;
    test_reset_mid;
    test_dec;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_serial_driver.md
Name: seg_serial_driver

Overview:
Parametrised driver for the board's serial seven-segment chain (SEGCLK/SEGDT/SEGEN/SEGCLR), replacing the fixed 8-digit hex packing done at top level.
- Accepts a packed value plus per-digit decimal-point and blank masks.
- Encodes each digit to active-low segment bytes and shifts the frame out at a programmable bit rate.
- Reports busy/done and queues one pending update.
- Sits beside GameCtrl; score/life (or any status word) feeds `value`.

Parameters:
DIGITS, 8, number of digits in the chain (1..16)
CLK_DIV, 4, clk cycles per seg_clk half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*DIGITS  digit nibbles, digit 0 = value[3:0] = rightmost (binary word in decimal mode)
dp_mask  in  DIGITS  1 = light decimal point of digit i
blank_mask  in  DIGITS  1 = blank digit i
dec_mode  in  1  1 = decimal display (only with SEG_BCD_EN)
update  in  1  request a new frame; sampled every cycle
busy  out  1  frame in progress (conversion or shifting)
done  out  1  one-cycle pulse at frame end
seg_clk  out  1  serial clock to chain
seg_dt  out  1  serial data
seg_en  out  1  display enable, 1 = show
seg_clr  out  1  chain clear, active-low

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: seg_clk=0, seg_dt=0, seg_en=0, seg_clr=0, busy=0, done=0, pending=0. State=CLR.
- Reset asserted mid-frame aborts immediately with the same values.
- States: CLR -> IDLE -> [CONV] -> SHIFT -> DONE -> IDLE.
- CLR: seg_clr held 0 for 2*CLK_DIV cycles after reset release, then seg_clr=1 and go to IDLE. seg_en stays 0 until the first completed frame.
- IDLE: on `update`, latch value/dp_mask/blank_mask/dec_mode into frame registers on that edge. Next cycle: busy=1, seg_en=0, enter SHIFT (or CONV if decimal).
- Encoding: byte = {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
  - Hex table: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - dp_mask[i]=1 clears bit7.
  - blank_mask[i]=1 gives FF, dp included.
- SHIFT order: digit DIGITS-1 first, digit 0 last; each byte MSB (dp) first. 8*DIGITS bits total.
- Bit timing: each bit spans 2*CLK_DIV cycles.
  - First CLK_DIV cycles: seg_clk=0, seg_dt=bit (changes only while seg_clk=0).
  - Next CLK_DIV cycles: seg_clk=1.
  - Chain samples on the seg_clk rising edge.
- Frame length: 16*DIGITS*CLK_DIV cycles (default 512).
- DONE: one cycle; done=1, seg_en=1, seg_clk=0, seg_dt=0, busy=0 from the following cycle.
- `update` while busy: set pending and overwrite the pending copy with the latest inputs (last request wins). Leaving DONE with pending=1 starts the next frame directly, without an IDLE visit; pending cleared.
- `update` in DONE cycle: counts as pending.
- `update` during CLR: ignored.
- Bit counter width ceil(log2(8*DIGITS)), divide counter width ceil(log2(CLK_DIV+1)). No wrap-around beyond the frame.
- Without the macro, dec_mode is ignored (hex always).

Optional Feature:
SEG_BCD_EN
- With macro: dec_mode=1 adds state CONV.
  - value is treated as unsigned binary; sequential double-dabble, one bit per cycle, 4*DIGITS cycles, then SHIFT.
  - Result > 10^DIGITS-1: every digit encodes BF (dash), dp_mask still applied.
  - Leading-zero blanking: zero digits above the most significant nonzero digit give FF; digit 0 is always shown.
  - blank_mask still overrides.
- Without macro: no CONV state, no BCD logic; dec_mode port present but unused.

Test Plan:
- Reset release, CLK_DIV=4 -> seg_clr=0 for 8 cycles then 1; seg_en=0, busy=0, no seg_clk edges until update.
- Hex, value=32'h0000_0001, masks 0 -> bytes C0 x7 then F9 in 64 rising seg_clk edges; done pulse at cycle 513 after update; seg_en=1 after.
- Hex, value=32'h1234_5678, dp_mask=8'h01, blank_mask=8'h80 -> FF,A4,B0,99,92,82,F8,00.
- update=1 at bit 10 with value=32'hFFFF_FFFF -> first frame completes unchanged; second frame starts cycle after done; eight 8E bytes.
- rst_n low at bit 30 -> all outputs 0 asynchronously; after release CLR sequence repeats, no residual shifting.
- SEG_BCD_EN, dec_mode=1:
  - value=1234 -> FF,FF,FF,FF,F9,A4,B0,99 after 32 CONV cycles.
  - value=100000000 -> BF x8.
